uart_image_loader: RTL and testbench

- Sits directly downstream of the UART byte receiver and turns its received-byte stream into sequential writes to the image data memory.
- Each frame is IMG_BYTES bytes. The loader is armed by the processor and streams bytes to consecutive addresses starting at 0.
- It flags completion, or flags a timeout error if the host stalls mid-frame.
- It keeps a running 8-bit additive checksum so host and processor can confirm the image arrived intact.

---
 rtl/uart_image_loader_if.sv | 33 +++
 rtl/uart_image_loader.sv | 136 +++++++++++++
 tb/tb_uart_image_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_image_loader_if.sv
// ============================================================================
// Module : uart_image_loader_if
// Brief  : Receiver-side inputs and memory-write outputs of the image loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface uart_image_loader_if #(
    parameter int ADDR_W = 16
);
    logic              Rx_done;
    logic [7:0]        RxD_data;
    logic              start;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              load_done;
    logic              load_err;
    logic [7:0]        checksum;

    modport master (
        output Rx_done, RxD_data, start,
        input  mem_we, mem_addr, mem_wdata, busy, load_done, load_err, checksum
    );

    modport slave (
        input  Rx_done, RxD_data, start,
        output mem_we, mem_addr, mem_wdata, busy, load_done, load_err, checksum
    );
endinterface

`default_nettype wire

// File: rtl/uart_image_loader.sv
// ============================================================================
// Module : uart_image_loader
// Brief  : Streams UART bytes into image memory with checksum and timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_image_loader #(
    parameter int IMG_BYTES      = 65536,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TO_W           = 20
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    uart_image_loader_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_FIRST = 3'd1,
        S_LOAD       = 3'd2,
        S_DONE       = 3'd3,
        S_ERR        = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BYTES - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    logic              rx_done_q;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [7:0]        sum_q, sum_d;
    logic [TO_W-1:0]   to_q, to_d;

    logic byte_strobe;
    logic take_byte;
    logic armed;

    assign byte_strobe = bus.Rx_done & ~rx_done_q;
    assign armed       = (state_q == S_WAIT_FIRST) || (state_q == S_LOAD);
    assign take_byte   = byte_strobe & armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rx_done_q <= 1'b1;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            sum_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            rx_done_q <= bus.Rx_done;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sum_q     <= sum_d;
            to_q      <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
        sum_d   = sum_q;
        to_d    = to_q;

        // Address advances the cycle after a write and parks on the last slot.
        if (we_q && (addr_q != LAST_ADDR)) begin
            addr_d = addr_q + 1'b1;
        end

        if (take_byte) begin
            we_d    = 1'b1;
            wdata_d = bus.RxD_data;
            sum_d   = sum_q + bus.RxD_data;
            to_d    = '0;
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d = S_WAIT_FIRST;
                    addr_d  = '0;
                    sum_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    to_d    = '0;
                end
            end
            S_WAIT_FIRST: begin
                if (take_byte) begin
                    state_d = (addr_q == LAST_ADDR) ? S_DONE : S_LOAD;
                    done_d  = (addr_q == LAST_ADDR);
                end
            end
            S_LOAD: begin
                if (take_byte) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = armed;
    assign bus.load_done = done_q;
    assign bus.load_err  = err_q;
    assign bus.checksum  = sum_q;
endmodule

`default_nettype wire

// File: tb/tb_uart_image_loader.sv
// ============================================================================
// Module : tb_uart_image_loader
// Brief  : Directed/randomized bench for uart_image_loader with a frame model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_uart_image_loader;
    localparam int IMG  = 4;
    localparam int AW   = 16;
    localparam int TO   = 50;
    localparam int TOW  = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_image_loader_if #(.ADDR_W(AW)) bus ();

    uart_image_loader #(
        .IMG_BYTES      (IMG),
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (TOW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of one frame: armed flag, next address, running sum.
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    bit         m_err  = 1'b0;
    int         m_addr = 0;
    logic [7:0] m_sum  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_addr();
        return (m_addr > IMG - 1) ? IMG - 1 : m_addr;
    endfunction

    task automatic idle(input int n, inout int cnt);
        repeat (n) begin
            @(negedge clk);
            if (bus.mem_we) cnt++;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int hold, input int gap);
        int  extra;
        bit  acc;
        int  ea;
        extra = 0;
        acc   = m_busy;
        @(posedge clk); #1;
        bus.Rx_done  = 1'b1;
        bus.RxD_data = d;
        idle(1, extra);
        @(negedge clk);
        chk("we_pulse", 32'(bus.mem_we), 32'(acc));
        if (acc) begin
            ea = m_addr;
            m_sum = m_sum + d;
            m_addr++;
            if (m_addr == IMG) begin
                m_done = 1'b1;
                m_busy = 1'b0;
            end
            chk("wr_addr", 32'(bus.mem_addr), 32'(ea));
            chk("wr_data", 32'(bus.mem_wdata), 32'(d));
            chk("wr_sum", 32'(bus.checksum), 32'(m_sum));
            chk("wr_done", 32'(bus.load_done), 32'(m_done));
            chk("wr_busy", 32'(bus.busy), 32'(m_busy));
        end
        idle(hold, extra);
        @(posedge clk); #1;
        bus.Rx_done = 1'b0;
        idle(gap, extra);
        chk("no_extra_we", 32'(extra), 32'd0);
        if (hold + gap > 0) chk("addr_after", 32'(bus.mem_addr), 32'(exp_addr()));
    endtask

    task automatic do_start(input bit with_byte, input logic [7:0] d);
        int extra;
        extra = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        if (with_byte) begin
            bus.Rx_done  = 1'b1;
            bus.RxD_data = d;
        end
        idle(1, extra);
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (!m_busy) begin
            m_busy = 1'b1;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_addr = 0;
            m_sum  = 8'h00;
        end
        idle(1, extra);
        chk("st_busy", 32'(bus.busy), 32'(m_busy));
        chk("st_done", 32'(bus.load_done), 32'(m_done));
        chk("st_err", 32'(bus.load_err), 32'(m_err));
        chk("st_sum", 32'(bus.checksum), 32'(m_sum));
        chk("st_addr", 32'(bus.mem_addr), 32'(exp_addr()));
        if (with_byte) begin
            idle(3, extra);
            @(posedge clk); #1;
            bus.Rx_done = 1'b0;
            idle(2, extra);
        end
        chk("st_no_we", 32'(extra), 32'd0);
    endtask

    task automatic rand_frame(input bit poke_start);
        for (int i = 0; i < IMG; i++) begin
            send_byte(8'($urandom), $urandom_range(0, 5), $urandom_range(0, 10));
            if (poke_start && i == 1) do_start(1'b0, 8'h00);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra;
        extra = 0;
        bus.Rx_done  = 1'b1;
        bus.RxD_data = 8'h00;
        bus.start    = 1'b0;

        // Reset released while Rx_done is already high.
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5, extra);
        chk("rst_no_we", 32'(extra), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_data", 32'(bus.mem_wdata), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.load_done), 32'd0);
        chk("rst_err", 32'(bus.load_err), 32'd0);
        chk("rst_sum", 32'(bus.checksum), 32'd0);
        @(posedge clk); #1;
        bus.Rx_done = 1'b0;
        idle(2, extra);

        // Nominal frame.
        do_start(1'b0, 8'h00);
        send_byte(8'h11, 2, 18);
        send_byte(8'h22, 2, 18);
        send_byte(8'h33, 2, 18);
        send_byte(8'h44, 2, 18);
        chk("frame1_sum", 32'(bus.checksum), 32'h0000_00AA);
        chk("frame1_done", 32'(bus.load_done), 32'd1);
        chk("frame1_addr_hold", 32'(bus.mem_addr), 32'(IMG - 1));

        // Held Rx_done, byte after DONE, restart.
        do_start(1'b0, 8'h00);
        send_byte(8'($urandom), 30, 5);
        send_byte(8'($urandom), 1, 3);
        send_byte(8'($urandom), 1, 3);
        send_byte(8'($urandom), 1, 3);
        send_byte(8'($urandom), 2, 3);

        // Inter-byte timeout.
        do_start(1'b0, 8'h00);
        send_byte(8'h80, 2, 10);
        send_byte(8'h90, 2, 0);
        extra = 0;
        idle(46, extra);
        chk("to_not_yet", 32'(bus.load_err), 32'd0);
        idle(4, extra);
        chk("to_err", 32'(bus.load_err), 32'd1);
        chk("to_busy", 32'(bus.busy), 32'd0);
        chk("to_sum", 32'(bus.checksum), 32'h0000_0010);
        chk("to_no_we", 32'(extra), 32'd0);
        m_err  = 1'b1;
        m_busy = 1'b0;
        send_byte(8'($urandom), 2, 2);

        // Byte before start, start coincident with a byte.
        send_byte(8'($urandom), 2, 2);
        do_start(1'b1, 8'($urandom));
        rand_frame(1'b0);

        // Asynchronous reset mid-load.
        do_start(1'b0, 8'h00);
        send_byte(8'($urandom), 1, 4);
        send_byte(8'($urandom), 1, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("ar_we", 32'(bus.mem_we), 32'd0);
        chk("ar_addr", 32'(bus.mem_addr), 32'd0);
        chk("ar_sum", 32'(bus.checksum), 32'd0);
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_done", 32'(bus.load_done), 32'd0);
        chk("ar_err", 32'(bus.load_err), 32'd0);
        m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_addr = 0; m_sum = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(1'b0, 8'h00);
        rand_frame(1'b0);
        chk("ar_frame_done", 32'(bus.load_done), 32'd1);

        // Randomized frames with an ignored start mid-load.
        repeat (3) begin
            do_start(1'b0, 8'h00);
            rand_frame(1'b1);
            chk("rf_done", 32'(bus.load_done), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
